rr_grant_sched: RTL and testbench

//  Round-robin scheduler that shares one downstream resource among 4 requesters.
//  It issues a one-hot grant plus its 2-bit encoded index, in the same style as the

---
 rtl/rr_grant_sched.sv | 92 +++++++++
 tb/tb_rr_grant_sched.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rr_grant_sched.sv
// Round-robin grant scheduler for 4 requesters with bounded hold and early release.
// Latency: REQ to GNT is 1 cycle; one mandatory dead cycle between consecutive grants.
// Backpressure: none; a requester stalls only by waiting for its grant or dropping REQ.
module rr_grant_sched #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] REQ,
  input  logic       DONE,
  output logic [3:0] GNT,
  output logic [1:0] GIDX,
  output logic       GVALID,
  output logic [9:0] CNT_DEC
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] timer;
  logic [3:0] cnt;

  logic       win_vld;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       leave;
  logic [3:0] cnt_nxt;

  // Search starts at ptr and wraps; first requester found wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr;
    cand    = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!win_vld && REQ[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    leave   = DONE | ~REQ[GIDX] | (timer == 4'(HOLD_CYCLES));
    cnt_nxt = (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
  end

  assign GVALID = |GNT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      GNT     <= 4'b0000;
      GIDX    <= 2'd0;
      ptr     <= 2'd0;
      timer   <= 4'd0;
      cnt     <= 4'd0;
      CNT_DEC <= 10'd1;
    end else begin
      case (state)
        IDLE, RELEASE: begin
          if (win_vld) begin
            GNT   <= 4'b0001 << win_idx;
            GIDX  <= win_idx;
            timer <= 4'd1;
            state <= GRANT;
          end else begin
            GNT   <= 4'b0000;
            state <= IDLE;
          end
        end
        GRANT: begin
          if (leave) begin
            GNT     <= 4'b0000;
            state   <= RELEASE;
            ptr     <= GIDX + 2'd1;
            cnt     <= cnt_nxt;
            CNT_DEC <= 10'd1 << cnt_nxt;
          end else begin
            timer <= timer + 4'd1;
          end
        end
        default: begin
          GNT   <= 4'b0000;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_sched.sv
// Bench for rr_grant_sched: per-cycle compare against an owner/length model plus directed literal checks.
module tb_rr_grant_sched;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] REQ = 4'b0000;
  logic       DONE = 1'b0;
  logic [3:0] GNT;
  logic [1:0] GIDX;
  logic       GVALID;
  logic [9:0] CNT_DEC;

  int total = 0;
  int bad   = 0;

  rr_grant_sched #(.HOLD_CYCLES(HOLD)) dut (
    .clk    (clk),
    .rst    (rst),
    .REQ    (REQ),
    .DONE   (DONE),
    .GNT    (GNT),
    .GIDX   (GIDX),
    .GVALID (GVALID),
    .CNT_DEC(CNT_DEC)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: who owns the resource, for how long, whose turn is next, grants completed.
  int m_owner = -1;
  int m_len   = 0;
  int m_last  = 0;
  int m_ptr   = 0;
  int m_cnt   = 0;
  bit m_armed = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_len = 0; m_last = 0; m_ptr = 0; m_cnt = 0; m_armed = 1;
    end else if (m_owner >= 0) begin
      if (DONE || !REQ[m_owner] || m_len == HOLD) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_cnt++;
      end else begin
        m_len++;
      end
    end else if (REQ != 4'b0000) begin
      for (int k = 0; k < 4; k++)
        if (m_owner < 0 && REQ[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
      m_last = m_owner;
      m_len  = 1;
    end
  end

  always @(negedge clk) begin
    if (m_armed) begin
      chk("cmp_gnt",    32'(GNT),     (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("cmp_gidx",   32'(GIDX),    32'(m_last));
      chk("cmp_gvalid", 32'(GVALID),  (m_owner >= 0) ? 32'd1 : 32'd0);
      chk("cmp_cntdec", 32'(CNT_DEC), 32'd1 << (m_cnt % 10));
    end
  end

  // Inputs change just after the falling edge; returns once post-edge outputs are compared.
  task automatic tick(input logic [3:0] r, input logic d, input logic rs);
    REQ = r; DONE = d; rst = rs;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] pat2 [10];
    bit found;
    pat2 = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0};

    // 1: reset held with all requesting
    tick(4'b1111, 1'b0, 1'b1);
    tick(4'b1111, 1'b0, 1'b1);
    chk("rst_gnt",    32'(GNT),     32'h0);
    chk("rst_gidx",   32'(GIDX),    32'h0);
    chk("rst_gvalid", 32'(GVALID),  32'h0);
    chk("rst_cntdec", 32'(CNT_DEC), 32'h1);

    // 2: single requester, full-length grants with a dead cycle
    for (int i = 0; i < 10; i++) begin
      tick(4'b0010, 1'b0, 1'b0);
      chk("t2_gnt", 32'(GNT), 32'(pat2[i]));
      if (i == 4) chk("t2_cntdec", 32'(CNT_DEC), 32'h2);
    end

    // 3: all requesting, rotation from requester 0
    tick(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 25; i++) begin
      tick(4'b1111, 1'b0, 1'b0);
      if (i % 5 == 0) begin
        chk("t3_gidx", 32'(GIDX), 32'((i / 5) % 4));
        chk("t3_gnt",  32'(GNT),  32'd1 << ((i / 5) % 4));
      end
      if (i == 4) chk("t3_gap", 32'(GNT), 32'h0);
    end

    // 4: early release by DONE in the second grant cycle
    tick(4'b0000, 1'b0, 1'b1);
    tick(4'b0101, 1'b0, 1'b0);
    chk("t4_g0", 32'(GNT), 32'h1);
    tick(4'b0101, 1'b0, 1'b0);
    chk("t4_g0c2", 32'(GNT), 32'h1);
    tick(4'b0101, 1'b1, 1'b0);
    chk("t4_rel", 32'(GNT), 32'h0);
    chk("t4_gidx_hold", 32'(GIDX), 32'h0);
    tick(4'b0101, 1'b0, 1'b0);
    chk("t4_g2", 32'(GNT), 32'h4);
    chk("t4_gidx", 32'(GIDX), 32'h2);

    // 5: REQ drop releases immediately; count wraps after 10 grants
    tick(4'b0101, 1'b0, 1'b0);
    tick(4'b0001, 1'b0, 1'b0);
    chk("t5_drop", 32'(GNT), 32'h0);
    chk("t5_cnt2", 32'(CNT_DEC), 32'h4);
    for (int i = 0; i < 8; i++) begin
      tick(4'b1111, 1'b0, 1'b0);
      tick(4'b0000, 1'b0, 1'b0);
      if (i == 6) chk("t5_cnt9", 32'(CNT_DEC), 32'h200);
    end
    chk("t5_wrap", 32'(CNT_DEC), 32'h1);

    // 6: reset aborts grant 2 in its third cycle
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(4'b1111, 1'b0, 1'b0);
      if (GNT == 4'b0100) found = 1;
    end
    chk("t6_found", 32'(found), 32'h1);
    tick(4'b1111, 1'b0, 1'b0);
    tick(4'b1111, 1'b0, 1'b0);
    chk("t6_c3", 32'(GNT), 32'h4);
    tick(4'b1111, 1'b0, 1'b1);
    chk("t6_gnt",    32'(GNT),     32'h0);
    chk("t6_gidx",   32'(GIDX),    32'h0);
    chk("t6_cntdec", 32'(CNT_DEC), 32'h1);
    tick(4'b1111, 1'b0, 1'b0);
    chk("t6_next", 32'(GNT), 32'h1);
    chk("t6_nidx", 32'(GIDX), 32'h0);
    tick(4'b0000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
